// File: rtl/seven_seg_pkg.sv
// ============================================================================
// seven_seg_pkg : shared hex LUT, scan state encodings and slot constants
// Rev 1.0
// ============================================================================
`default_nettype none

package seven_seg_pkg;

   localparam int SLOT_TICKS = 16;
   localparam int TICK_W     = $clog2(SLOT_TICKS);

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2,
      ST_DIM   = 2'd3
   } scan_state_e;

   // Segment order {g,f,e,d,c,b,a}; element 0 is the last entry of the concatenation.
   localparam logic [15:0][6:0] HEX_LUT = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h67, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      return HEX_LUT[nib];
   endfunction

   // Tick 0 of every slot is dead time; the lit window follows it.
   function automatic scan_state_e slot_state(input logic [TICK_W-1:0] t,
                                              input logic [3:0]        bright);
      if (t == '0)
         return ST_BLANK;
      else if (t <= bright)
         return ST_ON;
      else
         return ST_DIM;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seven_seg_scan_ctrl_if.sv
// ============================================================================
// seven_seg_scan_ctrl_if : shadow-bank write and swap handshake
// Rev 1.0
// ============================================================================
`default_nettype none

interface seven_seg_scan_ctrl_if;
   logic       i_Wr_Valid;
   logic [1:0] i_Wr_Digit;
   logic [6:0] i_Wr_Data;
   logic       o_Wr_Ready;
   logic       i_Swap;
   logic       o_Swap_Pend;

   modport master (
      output i_Wr_Valid, i_Wr_Digit, i_Wr_Data, i_Swap,
      input  o_Wr_Ready, o_Swap_Pend
   );

   modport slave (
      input  i_Wr_Valid, i_Wr_Digit, i_Wr_Data, i_Swap,
      output o_Wr_Ready, o_Swap_Pend
   );
endinterface

`default_nettype wire

// File: rtl/seven_seg_prescaler.sv
// ============================================================================
// seven_seg_prescaler : tick every i_Div+1 clocks, held at zero while cleared
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_prescaler #(
   parameter int DIV_W = 16
) (
   input  wire logic             i_Clk,
   input  wire logic             i_Rst_n,
   input  wire logic             i_Clr,
   input  wire logic [DIV_W-1:0] i_Div,
   output logic                  o_Tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             at_limit;

   // ">=" rather than "==" so lowering i_Div below the count ends the tick at once.
   always_comb begin
      at_limit = (cnt_q >= i_Div);
      o_Tick   = at_limit & ~i_Clr;
      if (i_Clr || at_limit)
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
// ============================================================================
// seven_seg_scan_ctrl : multiplexed 7-segment scan with dead time, PWM
//                       brightness and frame-synchronous shadow-bank commit
// Rev 1.0
// ============================================================================
`default_nettype none

module seven_seg_scan_ctrl
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int DIV_W      = 16
) (
   input  wire logic                  i_Clk,
   input  wire logic                  i_Rst_n,
   input  wire logic                  i_Enable,
   input  wire logic                  i_HexLutEn,
   input  wire logic [DIV_W-1:0]      i_Div,
   input  wire logic [3:0]            i_Bright,
   seven_seg_scan_ctrl_if.slave       wr,
   output logic                       o_Frame_Start,
   output logic [NUM_DIGITS-1:0]      o_7Seg_En,
   output logic [6:0]                 o_7Seg_Led
);

   localparam logic [1:0]        LAST_DIGIT = 2'(NUM_DIGITS - 1);
   localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(SLOT_TICKS - 1);

   scan_state_e                 state_q, state_d;
   logic [1:0]                  digit_q, digit_d;
   logic [TICK_W-1:0]           t_q, t_d;
   logic                        entry_q, entry_d;
   logic                        frame_start_q, frame_start_d;
   logic [NUM_DIGITS-1:0]       en_q, en_d;
   logic [6:0]                  led_q, led_d;
   logic                        pend_q, pend_d;
   logic                        live_q;
   logic [NUM_DIGITS-1:0][6:0]  active_q, active_d;
   logic [NUM_DIGITS-1:0][6:0]  shadow_q, shadow_d;

   logic tick;
   logic prescale_clr;
   logic frame_wrap;
   logic commit;
   logic wr_fire;

   assign prescale_clr = ~i_Enable | (state_q == ST_OFF);

   seven_seg_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .i_Clr   (prescale_clr),
      .i_Div   (i_Div),
      .o_Tick  (tick)
   );

   // Commit only on the tick leaving the last slot, or straight away when dark.
   always_comb begin
      frame_wrap = (t_q == LAST_TICK) && (digit_q == LAST_DIGIT);
      if (state_q == ST_OFF)
         commit = pend_q;
      else
         commit = pend_q & i_Enable & tick & frame_wrap;
   end

   assign wr.o_Wr_Ready  = live_q & ~commit;
   assign wr.o_Swap_Pend = pend_q;
   assign wr_fire        = wr.i_Wr_Valid & wr.o_Wr_Ready &
                           ({1'b0, wr.i_Wr_Digit} < 3'(NUM_DIGITS));

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      t_d     = t_q;
      entry_d = 1'b0;
      if (!i_Enable) begin
         state_d = ST_OFF;
         digit_d = '0;
         t_d     = '0;
      end else if (state_q == ST_OFF) begin
         state_d = ST_BLANK;
         digit_d = '0;
         t_d     = '0;
         entry_d = 1'b1;
      end else if (tick) begin
         if (t_q == LAST_TICK) begin
            t_d     = '0;
            digit_d = (digit_q == LAST_DIGIT) ? 2'd0 : digit_q + 2'd1;
            entry_d = (digit_q == LAST_DIGIT);
         end else begin
            t_d = t_q + 1'b1;
         end
         state_d = slot_state(t_d, i_Bright);
      end
   end

   always_comb begin
      en_d  = '0;
      led_d = '0;
      if (i_Enable && (state_q == ST_ON)) begin
         en_d[digit_q] = 1'b1;
         led_d         = i_HexLutEn ? hex_to_seg(active_q[digit_q][3:0])
                                    : active_q[digit_q];
      end
      frame_start_d = entry_q & i_Enable;
   end

   always_comb begin
      shadow_d = shadow_q;
      if (wr_fire)
         shadow_d[wr.i_Wr_Digit] = wr.i_Wr_Data;
      active_d = commit ? shadow_q : active_q;
      pend_d   = commit ? 1'b0 : (pend_q | wr.i_Swap);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q       <= ST_OFF;
         digit_q       <= '0;
         t_q           <= '0;
         entry_q       <= 1'b0;
         frame_start_q <= 1'b0;
         en_q          <= '0;
         led_q         <= '0;
         pend_q        <= 1'b0;
         live_q        <= 1'b0;
         active_q      <= '0;
         shadow_q      <= '0;
      end else begin
         state_q       <= state_d;
         digit_q       <= digit_d;
         t_q           <= t_d;
         entry_q       <= entry_d;
         frame_start_q <= frame_start_d;
         en_q          <= en_d;
         led_q         <= led_d;
         pend_q        <= pend_d;
         live_q        <= 1'b1;
         active_q      <= active_d;
         shadow_q      <= shadow_d;
      end
   end

   assign o_Frame_Start = frame_start_q;
   assign o_7Seg_En     = en_q;
   assign o_7Seg_Led    = led_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
// ============================================================================
// tb_seven_seg_scan_ctrl : table-driven scan checks plus swap/enable/reset sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seven_seg_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        hex_en = 1'b1;
   logic [15:0] div = '0;
   logic [3:0]  bright = 4'd15;
   logic        frame_start;
   logic [2:0]  seg_en;
   logic [6:0]  seg_led;

   int errors = 0;
   int checks = 0;

   seven_seg_scan_ctrl_if wr_if ();

   seven_seg_scan_ctrl #(
      .NUM_DIGITS (3),
      .DIV_W      (16)
   ) dut (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .i_Enable      (enable),
      .i_HexLutEn    (hex_en),
      .i_Div         (div),
      .i_Bright      (bright),
      .wr            (wr_if),
      .o_Frame_Start (frame_start),
      .o_7Seg_En     (seg_en),
      .o_7Seg_Led    (seg_led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]      dv;
      logic [3:0]       br;
      logic             hex;
      logic [2:0][6:0]  data;
      logic [2:0][6:0]  exp_led;
      int               frames;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr_digit(input logic [1:0] d, input logic [6:0] v, output logic acc);
      int n = 0;
      wr_if.i_Wr_Valid = 1'b1;
      wr_if.i_Wr_Digit = d;
      wr_if.i_Wr_Data  = v;
      while (!wr_if.o_Wr_Ready && n < 4) begin
         step();
         n++;
      end
      acc = wr_if.o_Wr_Ready;
      step();
      wr_if.i_Wr_Valid = 1'b0;
   endtask

   task automatic pulse_swap();
      wr_if.i_Swap = 1'b1;
      step();
      wr_if.i_Swap = 1'b0;
   endtask

   task automatic wait_frame_start(input string name);
      int n = 0;
      while (frame_start !== 1'b1 && n < 1000) begin
         step();
         n++;
      end
      check({name, " frame_start seen"}, frame_start, 1'b1);
   endtask

   task automatic wait_commit(input string name, output logic ready_at_commit);
      int n = 0;
      ready_at_commit = 1'b1;
      while (wr_if.o_Swap_Pend && n < 2000) begin
         ready_at_commit = wr_if.o_Wr_Ready;
         step();
         n++;
      end
      check({name, " pend cleared"}, wr_if.o_Swap_Pend, 1'b0);
   endtask

   // Called with the current sample at k=0 (frame start visible); compares every cycle.
   task automatic observe(input int nfr, input logic [15:0] dv, input logic [3:0] br,
                          input logic [2:0][6:0] exp_led, input string name);
      int tl, slen, flen, slot, tk;
      int bad_en = 0, bad_led = 0, bad_fs = 0;
      logic [2:0] een;
      logic [6:0] eled;
      logic       efs;
      tl   = int'(dv) + 1;
      slen = 16 * tl;
      flen = 3 * slen;
      for (int k = 0; k < nfr * flen; k++) begin
         slot = (k % flen) / slen;
         tk   = (k % slen) / tl;
         if (tk >= 1 && tk <= int'(br)) begin
            een  = 3'b001 << slot;
            eled = exp_led[slot];
         end else begin
            een  = 3'b000;
            eled = 7'h00;
         end
         efs = ((k % flen) == 0);
         if (seg_en !== een)        bad_en++;
         if (seg_led !== eled)      bad_led++;
         if (frame_start !== efs)   bad_fs++;
         step();
      end
      check({name, " en bad cycles"},  bad_en,  0);
      check({name, " led bad cycles"}, bad_led, 0);
      check({name, " fs bad cycles"},  bad_fs,  0);
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      logic acc, rdy;
      hex_en = v.hex;
      div    = v.dv;
      bright = v.br;
      for (int d = 0; d < 3; d++) begin
         wr_digit(2'(d), v.data[d], acc);
      end
      pulse_swap();
      wait_commit(name, rdy);
      wait_frame_start(name);
      observe(v.frames, v.dv, v.br, v.exp_led, name);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic acc, rdy;
      int   n, bad_old;

      wr_if.i_Wr_Valid = 1'b0;
      wr_if.i_Wr_Digit = '0;
      wr_if.i_Wr_Data  = '0;
      wr_if.i_Swap     = 1'b0;

      vecs[0] = '{16'd0, 4'd15, 1'b1, {7'h03, 7'h02, 7'h01}, {7'h4F, 7'h5B, 7'h06}, 1};
      vecs[1] = '{16'd3, 4'd4,  1'b1, {7'h03, 7'h02, 7'h01}, {7'h4F, 7'h5B, 7'h06}, 1};
      vecs[2] = '{16'd0, 4'd0,  1'b1, {7'h03, 7'h02, 7'h01}, {7'h4F, 7'h5B, 7'h06}, 2};
      vecs[3] = '{16'd1, 4'd7,  1'b0, {7'h7F, 7'h36, 7'h49}, {7'h7F, 7'h36, 7'h49}, 1};
      vecs[4] = '{16'd0, 4'd15, 1'b1, {7'h0F, 7'h0B, 7'h0A}, {7'h71, 7'h7C, 7'h77}, 1};
      vecs[5] = '{16'd2, 4'd15, 1'b1, {7'h18, 7'h7E, 7'h45}, {7'h7F, 7'h79, 7'h6D}, 1};

      // Reset state
      step(2);
      check("reset en",    seg_en, 3'b000);
      check("reset led",   seg_led, 7'h00);
      check("reset fs",    frame_start, 1'b0);
      check("reset ready", wr_if.o_Wr_Ready, 1'b0);
      check("reset pend",  wr_if.o_Swap_Pend, 1'b0);
      rst_n  = 1'b1;
      enable = 1'b1;
      step(2);
      check("ready after reset", wr_if.o_Wr_Ready, 1'b1);

      for (int i = 0; i < 6; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Mid-frame shadow write and swap; active bank must hold until the wrap.
      apply_vec(vecs[0], "swap prep");
      step(20);
      wr_digit(2'd0, 7'h04, acc);
      wr_digit(2'd1, 7'h05, acc);
      wr_digit(2'd2, 7'h06, acc);
      pulse_swap();
      check("pend after swap", wr_if.o_Swap_Pend, 1'b1);
      step(5);
      pulse_swap();
      n = 0;
      bad_old = 0;
      rdy = 1'b1;
      while (wr_if.o_Swap_Pend && n < 2000) begin
         if (!(seg_led inside {7'h00, 7'h06, 7'h5B, 7'h4F})) bad_old++;
         rdy = wr_if.o_Wr_Ready;
         step();
         n++;
      end
      check("swap pend cleared", wr_if.o_Swap_Pend, 1'b0);
      check("old values held while pending", bad_old, 0);
      check("ready low in commit cycle", rdy, 1'b0);
      wait_frame_start("swap");
      step();
      check("new d0 en",  seg_en, 3'b001);
      check("new d0 led", seg_led, 7'h66);
      step(16);
      check("new d1 en",  seg_en, 3'b010);
      check("new d1 led", seg_led, 7'h6D);
      step(16);
      check("new d2 en",  seg_en, 3'b100);
      check("new d2 led", seg_led, 7'h7D);
      // Shadow change without swap: a spurious second commit would show 07.
      wr_digit(2'd0, 7'h07, acc);
      wait_frame_start("single commit");
      observe(1, 16'd0, 4'd15, {7'h7D, 7'h6D, 7'h66}, "single commit");
      check("pend stays clear", wr_if.o_Swap_Pend, 1'b0);

      // Out-of-range digit index: accepted, discarded.
      wr_digit(2'd3, 7'h08, acc);
      check("digit3 write ready", acc, 1'b1);
      pulse_swap();
      wait_commit("digit3", rdy);
      wait_frame_start("digit3");
      observe(1, 16'd0, 4'd15, {7'h7D, 7'h6D, 7'h07}, "digit3");

      // Enable drop mid-ON.
      step(5);
      check("lit before disable en", seg_en, 3'b001);
      enable = 1'b0;
      step();
      check("disable en",  seg_en, 3'b000);
      check("disable led", seg_led, 7'h00);
      step(3);
      check("disabled fs", frame_start, 1'b0);
      check("disabled led", seg_led, 7'h00);
      enable = 1'b1;
      wait_frame_start("reenable");
      step();
      check("reenable d0 en",  seg_en, 3'b001);
      check("reenable d0 led", seg_led, 7'h07);

      // Asynchronous reset mid-frame.
      step(20);
      rst_n = 1'b0;
      #1;
      check("async rst en",    seg_en, 3'b000);
      check("async rst led",   seg_led, 7'h00);
      check("async rst ready", wr_if.o_Wr_Ready, 1'b0);
      step(2);
      rst_n = 1'b1;
      wait_frame_start("post reset");
      step();
      check("post reset d0 en",  seg_en, 3'b001);
      check("post reset d0 led", seg_led, 7'h3F);
      step(16);
      check("post reset d1 en",  seg_en, 3'b010);
      check("post reset d1 led", seg_led, 7'h3F);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
